// File: rtl/nmi_apb_pkg.sv
// Shared types and constants for the NMI-to-APB bridge.
package nmi_apb_pkg;

    localparam int unsigned STATE_W = 3;

    // Bridge FSM states; IDLE must stay at encoding 0 (reset value of the state flop).
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        GUARD  = 3'd4
    } apb_brg_state_e;

    // Read data returned to the NMI master on slave error or timeout.
    localparam logic [31:0] APB_ERR_RDATA = 32'hDEAD_BEEF;

    // Width of a counter that must hold the value t; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/dffr.sv
// Enabled D flop bank with asynchronous active-low clear to zero.
module dffr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: clear on reset, load when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nmi2apb_bridge.sv
// NMI responder that runs one APB SETUP/ACCESS transfer per NMI request,
// with an ACCESS-phase watchdog and a guard cycle after each completion.
module nmi2apb_bridge
    import nmi_apb_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH     = 32,
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA     = DATA_WIDTH'(APB_ERR_RDATA)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    nmi_valid_i,
    input  logic [ADDR_WIDTH-1:0]   nmi_addr_i,
    input  logic [DATA_WIDTH-1:0]   nmi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] nmi_wstrb_i,
    output logic                    nmi_ready_o,
    output logic [DATA_WIDTH-1:0]   nmi_rdata_o,
    output logic                    apb_psel_o,
    output logic                    apb_penable_o,
    output logic                    apb_pwrite_o,
    output logic [ADDR_WIDTH-1:0]   apb_paddr_o,
    output logic [DATA_WIDTH-1:0]   apb_pwdata_o,
    output logic [DATA_WIDTH/8-1:0] apb_pstrb_o,
    input  logic [DATA_WIDTH-1:0]   apb_prdata_i,
    input  logic                    apb_pready_i,
    input  logic                    apb_pslverr_i,
    output logic                    err_o,
    output logic                    timeout_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned CTL_WIDTH  = 5;

    apb_brg_state_e         state_q;
    apb_brg_state_e         state_d;
    logic [STATE_W-1:0]     state_raw;

    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   timeout_hit;

    logic                   req_en;
    logic [ADDR_WIDTH-1:0]  addr_aligned;

    logic                   psel_d;
    logic                   penable_d;
    logic                   ready_d;
    logic                   err_d;
    logic                   timeout_d;
    logic [DATA_WIDTH-1:0]  rdata_d;

    assign state_q      = apb_brg_state_e'(state_raw);
    assign addr_aligned = nmi_addr_i & ~ADDR_WIDTH'(3);
    assign cnt_inc      = cnt_q + CNT_WIDTH'(1);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

    // Next-state, counter and next-output decode; every registered output is computed here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_en    = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        rdata_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (nmi_valid_i) begin
                    req_en  = 1'b1;
                    cnt_d   = '0;
                    psel_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                end
                // pready wins over a coincident timeout.
                if (apb_pready_i) begin
                    ready_d = 1'b1;
                    err_d   = apb_pslverr_i;
                    if (apb_pslverr_i) begin
                        rdata_d = ERR_RDATA;
                    end else if (!apb_pwrite_o) begin
                        rdata_d = apb_prdata_i;
                    end
                    state_d = RESP;
                end else if (timeout_hit) begin
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = ERR_RDATA;
                    state_d   = RESP;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end

            RESP: begin
                state_d = GUARD;
            end

            // Upstream valid may linger one cycle past ready; ignore it here.
            GUARD: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    dffr #(.WIDTH(STATE_W)) u_state (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_raw)
    );

    // ACCESS-phase watchdog counter.
    dffr #(.WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (1'b1),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // Request latches, loaded only when a request is accepted in IDLE.
    dffr #(.WIDTH(ADDR_WIDTH)) u_paddr (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (req_en),
        .d     (addr_aligned),
        .q     (apb_paddr_o)
    );

    dffr #(.WIDTH(DATA_WIDTH)) u_pwdata (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (req_en),
        .d     (nmi_wdata_i),
        .q     (apb_pwdata_o)
    );

    dffr #(.WIDTH(STRB_WIDTH)) u_pstrb (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (req_en),
        .d     (nmi_wstrb_i),
        .q     (apb_pstrb_o)
    );

    dffr #(.WIDTH(1)) u_pwrite (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (req_en),
        .d     (|nmi_wstrb_i),
        .q     (apb_pwrite_o)
    );

    // APB handshake and NMI completion flags.
    dffr #(.WIDTH(CTL_WIDTH)) u_ctl (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (1'b1),
        .d     ({psel_d, penable_d, ready_d, err_d, timeout_d}),
        .q     ({apb_psel_o, apb_penable_o, nmi_ready_o, err_o, timeout_o})
    );

    // Response data; zero in every cycle except the ready pulse.
    dffr #(.WIDTH(DATA_WIDTH)) u_rdata (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .en    (1'b1),
        .d     (rdata_d),
        .q     (nmi_rdata_o)
    );

endmodule

// File: doc/nmi2apb_bridge.md
Name: nmi2apb_bridge

Overview:
NMI responder that terminates the bus's APB-side NMI master port and converts each NMI transfer into one APB3/APB4 transfer toward the flash controller and APB peripheral cluster. It accepts one NMI request, runs a SETUP and ACCESS phase on APB, then returns a single-cycle ready with read data. It adds a timeout watchdog and error reporting, so a dead APB slave cannot hang the core or the DMA.

Parameters:
ADDR_WIDTH, 32, NMI/APB address width.
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before a forced abort; 0 disables the timeout.
ERR_RDATA, 32'hDEAD_BEEF, rdata returned on error or timeout.

Ports:
clk_i  in  1  single clock
rst_n_i  in  1  reset, asynchronous, active-low
nmi_valid_i  in  1  request valid, held high until ready
nmi_addr_i  in  ADDR_WIDTH  byte address
nmi_wdata_i  in  DATA_WIDTH  write data
nmi_wstrb_i  in  DATA_WIDTH/8  byte strobes; 0 means read
nmi_ready_o  out  1  one-cycle completion pulse
nmi_rdata_o  out  DATA_WIDTH  read data, valid while nmi_ready_o=1
apb_psel_o  out  1  APB select
apb_penable_o  out  1  APB enable
apb_pwrite_o  out  1  APB write
apb_paddr_o  out  ADDR_WIDTH  APB address, word-aligned ([1:0]=0)
apb_pwdata_o  out  DATA_WIDTH  APB write data
apb_pstrb_o  out  DATA_WIDTH/8  APB strobes; 0 on reads
apb_prdata_i  in  DATA_WIDTH  APB read data
apb_pready_i  in  1  APB ready
apb_pslverr_i  in  1  APB slave error
err_o  out  1  one-cycle pulse coincident with nmi_ready_o when the transfer errored
timeout_o  out  1  one-cycle pulse coincident with nmi_ready_o when the transfer timed out

Behaviour:
- Async reset (rst_n_i=0) forces state IDLE and all outputs to 0, including address, data and strobe registers and the timeout counter. Reset mid-transfer aborts the APB transfer immediately, with no completion pulse.
- FSM states: IDLE, SETUP, ACCESS, RESP, GUARD.
- IDLE:
  - On nmi_valid_i=1, latch addr (low 2 bits cleared), wdata and wstrb.
  - pwrite = |wstrb.
  - Go to SETUP.
- SETUP: psel=1, penable=0, for exactly 1 cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; the counter increments each cycle.
  - On pready=1: capture prdata (reads only) and pslverr, then go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with pready=0: deassert psel/penable next cycle, flag timeout, go to RESP.
  - If pready and the timeout coincide, pready wins; no timeout is flagged.
- RESP:
  - nmi_ready_o=1 for exactly 1 cycle; psel=0, penable=0.
  - nmi_rdata_o = captured prdata on an error-free read; 0 on writes; ERR_RDATA on pslverr or timeout.
  - err_o pulses on pslverr or timeout; timeout_o pulses on timeout only.
  - Go to GUARD.
- GUARD: 1 cycle in which nmi_valid_i is ignored. This absorbs the upstream register-slice latency, where valid stays high one cycle after ready. Then go to IDLE.
- Latency, NMI valid to ready: 3 + N cycles, where N = ACCESS wait cycles (N ≥ 1). Minimum 4 cycles; zero-wait back-to-back throughput is 1 transfer per 5 cycles.
- Request fields are sampled only in IDLE. Changes to nmi_addr_i, wdata or wstrb while busy have no effect.
- nmi_rdata_o is 0 whenever nmi_ready_o=0.
- APB outputs are registered (no combinational path from NMI inputs to APB outputs).
- The counter clears on entry to SETUP and is ADDR-independent. Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- The shared package nmi_apb_pkg holds:
  - state enum type apb_brg_state_e {IDLE, SETUP, ACCESS, RESP, GUARD};
  - constant APB_ERR_RDATA, the default for ERR_RDATA.
- The state register and datapath latches use the existing dffr flop primitive.
- No further sub-module is needed; the timeout counter stays inline.

Test Plan:
- Zero-wait read: valid with addr 0x1000_0004, wstrb 0; slave pready=1 in the first ACCESS cycle with prdata 0x1234_5678 -> psel seen 2 cycles, penable 1 cycle, nmi_ready pulse at cycle 4 with rdata 0x1234_5678, err_o=0.
- Write with 3 wait states: addr 0x1000_0013, wdata 0xA5A5_A5A5, wstrb 0x3 -> paddr 0x1000_0010, pwrite=1, pstrb 0x3, ready at cycle 7, rdata 0.
- pslverr on read: pready=1 with pslverr=1 -> ready with rdata 0xDEAD_BEEF, err_o=1, timeout_o=0.
- Timeout: TIMEOUT_CYCLES=8, pready held 0 -> psel drops after 8 ACCESS cycles; ready pulse with err_o=1, timeout_o=1, rdata 0xDEAD_BEEF. A following normal read completes correctly.
- Back-to-back plus GUARD: valid held high one cycle past ready, then a new request -> exactly one APB transfer for the first request and the second starts from IDLE, 5 cycles apart; no duplicate transfer.
- Reset mid-ACCESS: assert rst_n_i=0 during wait states -> psel/penable/nmi_ready drop immediately. After release, the FSM is in IDLE and the next read succeeds.
